sparc_control_unit: RTL and testbench
=====================================

Name: sparc_control_unit

Overview:
- Hardwired multi-cycle FSM that sequences the SPARC datapath.
- Drives every register load enable, mux select, ALU opcode override and RAM handshake signal.
- Consumes IR, MOC, BCOND and TCOND from the datapath.
- Covers fetch, decode and execute for format-3 ALU ops, loads, stores, SETHI, CALL and Bicc; any other opcode enters an illegal-instruction trap sequence.

Parameters:
- MOC_TIMEOUT, 16: max cycles waiting for MOC before bus-error trap; range 1..255.
- TT_ILLEGAL, 4'h2: trap type placed on trap_type for an illegal opcode.
- TT_BUSERR, 4'h9: trap type placed on trap_type for a MOC timeout.

Ports:
- Clk  in  1  clock
- Clr  in  1  synchronous active-high reset
- IR  in  32  instruction register contents
- MOC  in  1  memory operation complete
- BCOND  in  1  branch condition true
- TCOND  in  1  trap condition true
- MAR_Ld, MDR_Ld, IR_Ld, PC_Ld, NPC_Ld, nPC_Clr, FR_Ld, PSR_Ld, TBR_Ld, TTR_Ld, WIM_Ld, RF_Load_Enable  out  1 each  load enables/clears
- MA, MB  out  2 each  ALU A/B source: MA 00 portA, 01 PSR, 10 WIM, 11 TBR; MB 00 portB, 01 imm, 10 MuxC, 11 MDR
- MC  out  1  0 PC, 1 nPC
- MM  out  1  0 memory, 1 ALU
- MNP  out  2  00 ALU, 01 nPC+8, 10 PC+disp, 11 nPC+4
- MP  out  2  00 zero, 01 TBR, 10 nPC+4, 11 nPC
- MSa  out  1  0 rs1, 1 rd
- MSc  out  2  00 rd, 01 r15, 10 r17, 11 r18
- MOP  out  1  0 IR op3, 1 OpXX
- OpXX  out  6  forced ALU opcode
- MOV  out  1  memory request
- RW  out  1  1 read, 0 write
- type  out  2  00 byte, 01 half, 10 word
- trap_type  out  4  current trap type (TT_ILLEGAL or TT_BUSERR), 0 otherwise
- state_out  out  5  current state for debug

Behaviour:
- Idle output vector: all enables 0, all selects 0, MOP 0, OpXX 0, MOV 0, RW 1, type 10, trap_type 0.
- Clr sampled high: next state RESET0, idle outputs registered, timeout counter 0. Clr mid-transaction abandons it with no further loads.
- Outputs are Moore, decoded from the registered state, plus registered decode fields captured in DECODE. Exception: IR_Ld, MDR_Ld and state advance in wait states are qualified by MOC combinationally.
- RESET0: PC_Ld with MP=00 (PC=0), nPC_Clr=1 → RESET1.
- RESET1: NPC_Ld with MNP=11 (nPC=4) → FETCH0.
- FETCH0: MAR_Ld, MB=10, MC=0, MOP=1, OpXX=ALU_PASSB → FETCH1.
- FETCH1: MOV=1, RW=1, type=10, MM=0. If MOC: IR_Ld → DECODE.
- Wait-state rule (FETCH1, LD_WAIT, ST_WAIT): each cycle without MOC increments the counter. Counter reaching MOC_TIMEOUT → TRAP with trap_type=TT_BUSERR. Counter clears on entry to any wait state. MOC on the same cycle the limit is reached counts as success.
- DECODE, on op=IR[31:30]:
  - 01 → CALL
  - 00 with op2=IR[24:22]: 100 → SETHI; 010 → BRANCH; else → TRAP (illegal)
  - 10 → ALU
  - 11 with op3 ∈ {00_0000, 00_0001, 00_0010} → MEM_ADDR (load)
  - 11 with op3 ∈ {00_0100, 00_0101, 00_0110} → MEM_ADDR (store)
  - other 11 → TRAP
  - type derived from op3[1:0]: 00 word, 01 byte, 10 half.
- ALU:
  - MSa=0, MB=00 if IR[13]=0 else 01, MOP=0, RF_Load_Enable, MSc=00.
  - FR_Ld when op3[4]=1 (cc variants).
  - → UPDATE.
- SETHI: MB=01, MOP=1, OpXX=ALU_PASSB, RF_Load_Enable, MSc=00 → UPDATE.
- CALL:
  - r15←PC: MB=10, MC=0, MOP=1, OpXX=ALU_PASSB, RF_Load_Enable, MSc=01.
  - Same cycle: NPC_Ld with MNP=10 and PC_Ld with MP=11. Both registers sample old values on the same edge.
  - → FETCH0.
- BRANCH, evaluated from BCOND and annul bit a=IR[29]:
  - BCOND=1: PC←nPC (MP=11), nPC←PC+disp (MNP=10).
  - BCOND=0, a=0: PC←nPC, nPC←nPC+4.
  - BCOND=0, a=1: PC←nPC+4 (MP=10), nPC←nPC+8 (MNP=01).
  - → FETCH0.
- MEM_ADDR: MAR_Ld, MSa=0, MB per IR[13], MOP=1, OpXX=ALU_ADD.
  - Load → LD_WAIT.
  - Store: MSa=1, MDR_Ld with MM=1 happens in ST_DATA, then → ST_WAIT.
- LD_WAIT: MOV=1, RW=1, type per op3, MM=0. If MOC: MDR_Ld → LD_WB.
- LD_WB: MB=11, MOP=1, OpXX=ALU_PASSB, RF_Load_Enable, MSc=00 → UPDATE.
- ST_DATA: MSa=1, MB=00, MOP=1, OpXX=ALU_PASSB, MM=1, MDR_Ld → ST_WAIT.
- ST_WAIT: MOV=1, RW=0, type per op3. If MOC → UPDATE.
- UPDATE: PC_Ld with MP=11, NPC_Ld with MNP=11 → FETCH0.
- TRAP:
  - TTR_Ld with trap_type on OpXX path.
  - Next cycle: PC_Ld with MP=01, nPC_Clr.
  - → FETCH0.
  - TCOND is ignored in this revision.

Decomposition:
- Package sparc_ctrl_pkg holds:
  - state enum (RESET0 … TRAP, 5-bit)
  - mux select constants
  - ALU_ADD=6'h00 and ALU_PASSB=6'h16
  - op/op2/op3 field constants
- One sub-module, sparc_moc_timer: a counter with clear, enable and a limit-reached output.

Test Plan:
- Clr held 2 cycles then released → RESET0, RESET1, FETCH0 sequence; PC_Ld with MP=00, then NPC_Ld with MNP=11; all other outputs idle during Clr.
- IR=add r1,r2,r3 (32'h86004002), MOC on first FETCH1 cycle → states FETCH0, FETCH1, DECODE, ALU, UPDATE; RF_Load_Enable=1 only in ALU; FR_Ld=0.
- Load word, MOC delayed 3 cycles in LD_WAIT → MOV=1 and RW=1 for 4 cycles, MDR_Ld pulses once, then LD_WB asserts RF_Load_Enable with MB=11.
- Bicc with a=1, BCOND=0 → MP=10 and MNP=01 in BRANCH; with BCOND=1 → MP=11 and MNP=10.
- MOC never asserts in FETCH1, MOC_TIMEOUT=16 → TRAP entered after 16 wait cycles with trap_type=9, then PC_Ld with MP=01.
- IR=32'h00000000 (UNIMP) → TRAP with trap_type=2; CALL → RF_Load_Enable with MSc=01, and PC_Ld and NPC_Ld on the same cycle.

Source files
------------

// File: rtl/sparc_ctrl_pkg.sv
// sparc_ctrl_pkg: control-unit states, mux select codes, forced ALU opcodes and instruction field codes
package sparc_ctrl_pkg;
  typedef enum logic [4:0] {
    RESET0, RESET1, FETCH0, FETCH1, DECODE, ALU, SETHI, CALL, BRANCH, MEM_ADDR,
    LD_WAIT, LD_WB, ST_DATA, ST_WAIT, UPDATE, TRAP, TRAP_VEC
  } state_t;
  localparam logic [1:0] MA_PORTA = 2'b00;
  localparam logic [1:0] MB_PORTB = 2'b00, MB_IMM = 2'b01, MB_MUXC = 2'b10, MB_MDR = 2'b11;
  localparam logic [1:0] MNP_NPC8 = 2'b01, MNP_DISP = 2'b10, MNP_NPC4 = 2'b11;
  localparam logic [1:0] MP_ZERO = 2'b00, MP_TBR = 2'b01, MP_NPC4 = 2'b10, MP_NPC = 2'b11;
  localparam logic [1:0] MSC_RD = 2'b00, MSC_R15 = 2'b01;
  localparam logic [1:0] TY_BYTE = 2'b00, TY_HALF = 2'b01, TY_WORD = 2'b10;
  localparam logic [5:0] ALU_ADD = 6'h00, ALU_PASSB = 6'h16;
  localparam logic [1:0] OP_FMT2 = 2'b00, OP_CALL = 2'b01, OP_ALU = 2'b10;
  localparam logic [2:0] OP2_BICC = 3'b010, OP2_SETHI = 3'b100;
  localparam logic [5:0] OP3_LD = 6'h00, OP3_LDUB = 6'h01, OP3_LDUH = 6'h02;
  localparam logic [5:0] OP3_ST = 6'h04, OP3_STB = 6'h05, OP3_STH = 6'h06;
  function automatic logic [1:0] mem_type(input logic [1:0] sz);
    return sz == 2'b01 ? TY_BYTE : sz == 2'b10 ? TY_HALF : TY_WORD;
  endfunction
endpackage

// File: rtl/sparc_moc_timer.sv
// sparc_moc_timer: counts wait cycles without MOC; hit_o flags the cycle whose miss reaches LIMIT
// Ports: clk clock, clr_i synchronous clear, en_i count enable (a miss this cycle), hit_o limit reached
module sparc_moc_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);
  logic [7:0] cnt_q;
  always_ff @(posedge clk) cnt_q <= clr_i ? 8'd0 : en_i ? cnt_q + 8'd1 : cnt_q;
  assign hit_o = en_i && cnt_q == 8'(LIMIT - 1);
endmodule

// File: rtl/sparc_control_unit.sv
// sparc_control_unit: hardwired multi-cycle FSM sequencing the SPARC datapath
// Inputs: Clk, Clr (sync reset), IR, MOC, BCOND, TCOND (unused). Outputs: register load enables,
// ALU/register/PC mux selects, ALU opcode override, RAM handshake (MOV/RW/Type), trap_type, state_out.
module sparc_control_unit
  import sparc_ctrl_pkg::*;
#(
  parameter int         MOC_TIMEOUT = 16,
  parameter logic [3:0] TT_ILLEGAL  = 4'h2,
  parameter logic [3:0] TT_BUSERR   = 4'h9
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic [31:0] IR,
  input  logic        MOC,
  input  logic        BCOND,
  input  logic        TCOND,
  output logic        MAR_Ld, MDR_Ld, IR_Ld, PC_Ld, NPC_Ld, nPC_Clr,
  output logic        FR_Ld, PSR_Ld, TBR_Ld, TTR_Ld, WIM_Ld, RF_Load_Enable,
  output logic [1:0]  MA, MB,
  output logic        MC, MM,
  output logic [1:0]  MNP, MP,
  output logic        MSa,
  output logic [1:0]  MSc,
  output logic        MOP,
  output logic [5:0]  OpXX,
  output logic        MOV, RW,
  output logic [1:0]  Type,
  output logic [3:0]  trap_type,
  output logic [4:0]  state_out
);
  state_t state_q, state_d, dec_s;
  logic init_q, imm_q, cc_q, st_q, an_q, bc_q, in_wait, to_hit, unused_ok;
  logic [1:0] ty_q, op;
  logic [2:0] op2;
  logic [3:0] tt_q;
  logic [5:0] op3;
  assign op = IR[31:30];
  assign op2 = IR[24:22];
  assign op3 = IR[24:19];
  assign unused_ok = ^{TCOND, IR[28:25], IR[18:14], IR[12:0]};
  assign state_out = state_q;
  assign in_wait = state_q inside {FETCH1, LD_WAIT, ST_WAIT};
  sparc_moc_timer #(.LIMIT(MOC_TIMEOUT)) u_timer (
    .clk(Clk), .clr_i(Clr || !in_wait), .en_i(!MOC), .hit_o(to_hit)
  );
  assign dec_s = op == OP_CALL ? CALL : op == OP_ALU ? ALU :
                 op == OP_FMT2 ? (op2 == OP2_SETHI ? SETHI : op2 == OP2_BICC ? BRANCH : TRAP) :
                 op3 inside {OP3_LD, OP3_LDUB, OP3_LDUH, OP3_ST, OP3_STB, OP3_STH} ? MEM_ADDR : TRAP;
  always_comb begin
    state_d = RESET0;
    case (state_q)
      RESET0:                           state_d = init_q ? RESET0 : RESET1;
      RESET1, CALL, BRANCH, UPDATE, TRAP_VEC: state_d = FETCH0;
      FETCH0:                           state_d = FETCH1;
      FETCH1:                           state_d = MOC ? DECODE : to_hit ? TRAP : FETCH1;
      DECODE:                           state_d = dec_s;
      ALU, SETHI, LD_WB:                state_d = UPDATE;
      MEM_ADDR:                         state_d = st_q ? ST_DATA : LD_WAIT;
      LD_WAIT:                          state_d = MOC ? LD_WB : to_hit ? TRAP : LD_WAIT;
      ST_DATA:                          state_d = ST_WAIT;
      ST_WAIT:                          state_d = MOC ? UPDATE : to_hit ? TRAP : ST_WAIT;
      TRAP:                             state_d = TRAP_VEC;
      default:                          state_d = RESET0;
    endcase
  end
  // init_q marks the cycles following a sampled Clr: outputs stay idle and RESET0 is held once more
  // so that its PC/nPC initialisation is presented only after Clr is released.
  // tt_q only matters in the trap states: a trap out of DECODE is illegal, one out of a wait is a bus error.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q <= RESET0;
      init_q <= 1'b1;
    end else begin
      state_q <= state_d;
      init_q <= 1'b0;
    end
    if (state_q == DECODE) begin
      imm_q <= IR[13];
      cc_q <= op3[4];
      st_q <= op3[2];
      an_q <= IR[29];
      bc_q <= BCOND;
      ty_q <= mem_type(op3[1:0]);
      tt_q <= TT_ILLEGAL;
    end else if (in_wait) tt_q <= TT_BUSERR;
  end
  always_comb begin
    {MAR_Ld, MDR_Ld, IR_Ld, PC_Ld, NPC_Ld, nPC_Clr} = '0;
    {FR_Ld, PSR_Ld, TBR_Ld, TTR_Ld, WIM_Ld, RF_Load_Enable} = '0;
    MA = MA_PORTA;
    MB = MB_PORTB;
    MC = 1'b0;
    MM = 1'b0;
    MNP = 2'b00;
    MP = MP_ZERO;
    MSa = 1'b0;
    MSc = MSC_RD;
    MOP = 1'b0;
    OpXX = ALU_ADD;
    MOV = 1'b0;
    RW = 1'b1;
    Type = TY_WORD;
    trap_type = 4'h0;
    if (!init_q)
      case (state_q)
        RESET0: {PC_Ld, nPC_Clr} = 2'b11;
        RESET1: {NPC_Ld, MNP} = {1'b1, MNP_NPC4};
        FETCH0: {MAR_Ld, MB, MOP, OpXX} = {1'b1, MB_MUXC, 1'b1, ALU_PASSB};
        FETCH1: {MOV, IR_Ld} = {1'b1, MOC};
        ALU: {MB, RF_Load_Enable, FR_Ld} = {1'b0, imm_q, 1'b1, cc_q};
        SETHI: {MB, MOP, OpXX, RF_Load_Enable} = {MB_IMM, 1'b1, ALU_PASSB, 1'b1};
        CALL: begin
          {MB, MOP, OpXX, RF_Load_Enable, MSc} = {MB_MUXC, 1'b1, ALU_PASSB, 1'b1, MSC_R15};
          {NPC_Ld, MNP, PC_Ld, MP} = {1'b1, MNP_DISP, 1'b1, MP_NPC};
        end
        BRANCH: begin
          {PC_Ld, NPC_Ld} = 2'b11;
          MP = bc_q || !an_q ? MP_NPC : MP_NPC4;
          MNP = bc_q ? MNP_DISP : an_q ? MNP_NPC8 : MNP_NPC4;
        end
        MEM_ADDR: {MAR_Ld, MB, MOP, OpXX} = {1'b1, 1'b0, imm_q, 1'b1, ALU_ADD};
        LD_WAIT: {MOV, Type, MDR_Ld} = {1'b1, ty_q, MOC};
        LD_WB: {MB, MOP, OpXX, RF_Load_Enable} = {MB_MDR, 1'b1, ALU_PASSB, 1'b1};
        ST_DATA: {MSa, MOP, OpXX, MM, MDR_Ld} = {1'b1, 1'b1, ALU_PASSB, 1'b1, 1'b1};
        ST_WAIT: {MOV, RW, Type} = {1'b1, 1'b0, ty_q};
        UPDATE: {PC_Ld, MP, NPC_Ld, MNP} = {1'b1, MP_NPC, 1'b1, MNP_NPC4};
        TRAP: {TTR_Ld, MOP, OpXX, trap_type} = {1'b1, 1'b1, 2'b00, tt_q, tt_q};
        TRAP_VEC: {PC_Ld, MP, nPC_Clr, trap_type} = {1'b1, MP_TBR, 1'b1, tt_q};
        default: ;
      endcase
  end
endmodule

// File: tb/tb_sparc_control_unit.sv
// tb_sparc_control_unit: per-instruction expected cycle traces checked against the control unit every cycle
module tb_sparc_control_unit;
  localparam int TO = 16;
  localparam int S_RESET0 = 0, S_RESET1 = 1, S_FETCH0 = 2, S_FETCH1 = 3, S_DECODE = 4, S_ALU = 5;
  localparam int S_SETHI = 6, S_CALL = 7, S_BRANCH = 8, S_MEMA = 9, S_LDW = 10, S_LDWB = 11;
  localparam int S_STD = 12, S_STW = 13, S_UPD = 14, S_TRAP = 15, S_TRAPV = 16;
  typedef struct packed {
    logic mar, mdr, ir, pc, npc, nclr, fr, psr, tbr, ttr, wim, rf;
    logic [1:0] ma, mb;
    logic mc, mm;
    logic [1:0] mnp, mp;
    logic msa;
    logic [1:0] msc;
    logic mop;
    logic [5:0] opxx;
    logic mov, rw;
    logic [1:0] ty;
    logic [3:0] tt;
  } out_t;
  typedef struct {
    logic [4:0] st;
    out_t o;
    bit moc;
    bit clr;
  } cyc_t;
  logic Clk, Clr, MOC, BCOND, TCOND;
  logic [31:0] IR;
  logic MAR_Ld, MDR_Ld, IR_Ld, PC_Ld, NPC_Ld, nPC_Clr, FR_Ld, PSR_Ld, TBR_Ld, TTR_Ld, WIM_Ld, RF_Load_Enable;
  logic [1:0] MA, MB, MNP, MP, MSc, Type;
  logic MC, MM, MSa, MOP, MOV, RW;
  logic [5:0] OpXX;
  logic [3:0] trap_type;
  logic [4:0] state_out;
  cyc_t q[$];
  int n_cmp = 0, n_bad = 0, ncyc = 0;
  sparc_control_unit #(.MOC_TIMEOUT(TO), .TT_ILLEGAL(4'h2), .TT_BUSERR(4'h9)) dut (
    .Clk(Clk), .Clr(Clr), .IR(IR), .MOC(MOC), .BCOND(BCOND), .TCOND(TCOND),
    .MAR_Ld(MAR_Ld), .MDR_Ld(MDR_Ld), .IR_Ld(IR_Ld), .PC_Ld(PC_Ld), .NPC_Ld(NPC_Ld), .nPC_Clr(nPC_Clr),
    .FR_Ld(FR_Ld), .PSR_Ld(PSR_Ld), .TBR_Ld(TBR_Ld), .TTR_Ld(TTR_Ld), .WIM_Ld(WIM_Ld),
    .RF_Load_Enable(RF_Load_Enable), .MA(MA), .MB(MB), .MC(MC), .MM(MM), .MNP(MNP), .MP(MP),
    .MSa(MSa), .MSc(MSc), .MOP(MOP), .OpXX(OpXX), .MOV(MOV), .RW(RW), .Type(Type),
    .trap_type(trap_type), .state_out(state_out)
  );
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  function automatic out_t idle();
    out_t o;
    o = '0;
    o.rw = 1'b1;
    o.ty = 2'b10;
    return o;
  endfunction
  task automatic put(input int st, input out_t o, input bit moc, input bit clr);
    cyc_t c;
    c.st = 5'(st);
    c.o = o;
    c.moc = moc;
    c.clr = clr;
    q.push_back(c);
  endtask
  task automatic reset_tail();
    out_t o;
    put(S_RESET0, idle(), 0, 0);
    o = idle(); o.pc = 1; o.mp = 2'b00; o.nclr = 1;
    put(S_RESET0, o, 0, 0);
    o = idle(); o.npc = 1; o.mnp = 2'b11;
    put(S_RESET1, o, 0, 0);
  endtask
  task automatic trap(input logic [3:0] tt);
    out_t o;
    o = idle(); o.ttr = 1; o.mop = 1; o.opxx = {2'b00, tt}; o.tt = tt;
    put(S_TRAP, o, 0, 0);
    o = idle(); o.pc = 1; o.mp = 2'b01; o.nclr = 1; o.tt = tt;
    put(S_TRAPV, o, 0, 0);
  endtask
  task automatic update();
    out_t o;
    o = idle(); o.pc = 1; o.mp = 2'b11; o.npc = 1; o.mnp = 2'b11;
    put(S_UPD, o, 0, 0);
  endtask
  // res: 0 completed, 1 timed out into the bus-error trap, 2 abandoned by Clr
  task automatic wait_mem(input int st, input out_t base, input int delay, input int abort, output int res);
    out_t o;
    for (int k = 0; k < TO; k++) begin
      o = base;
      if (k == abort) begin
        put(st, o, 0, 1);
        res = 2;
        return;
      end
      if (k == delay) begin
        if (st == S_FETCH1) o.ir = 1;
        if (st == S_LDW) o.mdr = 1;
        put(st, o, 1, 0);
        res = 0;
        return;
      end
      put(st, o, 0, 0);
    end
    trap(4'h9);
    res = 1;
  endtask
  task automatic exec(input logic [31:0] ir, input bit bc, input int fw, input int mw, input int abort);
    out_t o;
    int r;
    logic [1:0] op, sz;
    logic [2:0] op2;
    logic [5:0] op3;
    op = ir[31:30]; op2 = ir[24:22]; op3 = ir[24:19];
    sz = op3[1:0] == 2'd0 ? 2'b10 : op3[1:0] == 2'd1 ? 2'b00 : 2'b01;
    o = idle(); o.mar = 1; o.mb = 2'b10; o.mop = 1; o.opxx = 6'h16;
    put(S_FETCH0, o, 0, 0);
    o = idle(); o.mov = 1;
    wait_mem(S_FETCH1, o, fw, -1, r);
    if (r != 0) return;
    put(S_DECODE, idle(), 0, 0);
    o = idle();
    if (op == 2'b01) begin
      o.mb = 2'b10; o.mop = 1; o.opxx = 6'h16; o.rf = 1; o.msc = 2'b01;
      o.npc = 1; o.mnp = 2'b10; o.pc = 1; o.mp = 2'b11;
      put(S_CALL, o, 0, 0);
    end else if (op == 2'b10) begin
      o.mb = ir[13] ? 2'b01 : 2'b00; o.rf = 1; o.fr = op3[4];
      put(S_ALU, o, 0, 0);
      update();
    end else if (op == 2'b00 && op2 == 3'b100) begin
      o.mb = 2'b01; o.mop = 1; o.opxx = 6'h16; o.rf = 1;
      put(S_SETHI, o, 0, 0);
      update();
    end else if (op == 2'b00 && op2 == 3'b010) begin
      o.pc = 1; o.npc = 1;
      if (bc) begin o.mp = 2'b11; o.mnp = 2'b10; end
      else if (!ir[29]) begin o.mp = 2'b11; o.mnp = 2'b11; end
      else begin o.mp = 2'b10; o.mnp = 2'b01; end
      put(S_BRANCH, o, 0, 0);
    end else if (op == 2'b11 && (op3 inside {6'h00, 6'h01, 6'h02, 6'h04, 6'h05, 6'h06})) begin
      o.mar = 1; o.mb = ir[13] ? 2'b01 : 2'b00; o.mop = 1; o.opxx = 6'h00;
      put(S_MEMA, o, 0, 0);
      if (op3[2] == 1'b0) begin
        o = idle(); o.mov = 1; o.ty = sz;
        wait_mem(S_LDW, o, mw, abort, r);
        if (r == 2) reset_tail();
        if (r != 0) return;
        o = idle(); o.mb = 2'b11; o.mop = 1; o.opxx = 6'h16; o.rf = 1;
        put(S_LDWB, o, 0, 0);
      end else begin
        o = idle(); o.msa = 1; o.mop = 1; o.opxx = 6'h16; o.mm = 1; o.mdr = 1;
        put(S_STD, o, 0, 0);
        o = idle(); o.mov = 1; o.rw = 0; o.ty = sz;
        wait_mem(S_STW, o, mw, abort, r);
        if (r == 2) reset_tail();
        if (r != 0) return;
      end
      update();
    end else trap(4'h2);
  endtask
  task automatic run();
    cyc_t c;
    out_t act;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge Clk);
      MOC = c.moc;
      Clr = c.clr;
      #1;
      ncyc++;
      act = {MAR_Ld, MDR_Ld, IR_Ld, PC_Ld, NPC_Ld, nPC_Clr, FR_Ld, PSR_Ld, TBR_Ld, TTR_Ld, WIM_Ld,
             RF_Load_Enable, MA, MB, MC, MM, MNP, MP, MSa, MSc, MOP, OpXX, MOV, RW, Type, trap_type};
      n_cmp++;
      if (state_out !== c.st || act !== c.o) begin
        n_bad++;
        $display("FAIL cycle %0d: state_out=%0d outputs=%h, required state_out=%0d outputs=%h",
                 ncyc, state_out, act, c.st, c.o);
      end
    end
  endtask
  task automatic pin(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL model_%s: got %0d required %0d", nm, got, exp);
    end
  endtask
  task automatic go(input logic [31:0] ir, input bit bc, input int fw, input int mw, input int abort);
    IR = ir;
    BCOND = bc;
    exec(ir, bc, fw, mw, abort);
    run();
  endtask
  initial begin
    Clr = 1'b1; MOC = 1'b0; IR = '0; BCOND = 1'b0; TCOND = 1'b0;
    put(S_RESET0, idle(), 0, 1);
    reset_tail();
    run();
    IR = 32'h86004002; BCOND = 0;
    exec(IR, 0, 0, 99, -1);
    pin("add_len", q.size(), 5);
    pin("add_rf", int'(q[3].o.rf), 1);
    run();
    go(32'h86806005, 0, 2, 99, -1);
    IR = 32'hC4006004;
    exec(IR, 0, 0, 3, -1);
    pin("ldw_len", q.size(), 10);
    pin("ldw_mdr", int'(q[7].o.mdr), 1);
    run();
    go(32'hC4106004, 0, 1, 0, -1);
    go(32'hC4284000, 0, 1, 2, -1);
    go(32'h03000010, 0, 0, 99, -1);
    go(32'h40000010, 0, 0, 99, -1);
    TCOND = 1'b1;
    IR = 32'h30800004; BCOND = 0;
    exec(IR, 0, 0, 99, -1);
    pin("br_a1_mp", int'(q[3].o.mp), 2);
    pin("br_a1_mnp", int'(q[3].o.mnp), 1);
    run();
    go(32'h30800004, 1, 0, 99, -1);
    go(32'h10800004, 0, 0, 99, -1);
    TCOND = 1'b0;
    IR = 32'h86004002;
    exec(IR, 0, 99, 99, -1);
    pin("to_len", q.size(), 19);
    pin("to_tt", int'(q[18].o.tt), 9);
    run();
    go(32'h86004002, 0, TO - 1, 99, -1);
    go(32'h00000000, 0, 0, 99, -1);
    go(32'hC0180000, 0, 0, 99, -1);
    go(32'hC4284000, 0, 0, 99, -1);
    go(32'hC4006004, 0, 0, 5, 1);
    go(32'h86004002, 0, 0, 99, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
